// File: rtl/riscv_dmem_interface_split.sv
// Sequential LSU-to-memory adapter: aligns stores, extracts and extends loads,
// and splits word-crossing accesses into two handshaked memory beats.
//
// Handshakes: the CPU request is taken on a cycle where i_dmem_intf_req and
// o_dmem_intf_ready are both high. A memory request is taken on a cycle where
// o_mem_req and i_mem_gnt are both high. o_mem_* are held stable until then.
// Read data is taken on i_mem_rd_valid only in a WAIT state.
module riscv_dmem_interface_split #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_dmem_intf_req,
    input  logic              i_dmem_intf_we,
    input  logic [XLEN-1:0]   i_dmem_intf_addr,
    input  logic [XLEN-1:0]   i_dmem_intf_wr_data,
    input  logic [2:0]        i_dmem_intf_func3,
    output logic              o_dmem_intf_ready,
    output logic              o_dmem_intf_done,
    output logic [XLEN-1:0]   o_dmem_intf_rd_data,
    output logic              o_dmem_intf_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [XLEN/8-1:0] o_mem_byte_sel,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rd_valid,
    input  logic [XLEN-1:0]   i_mem_rd_data
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            we_q, we_d;
    logic            cross_q, cross_d;
    logic [2:0]      f3_q, f3_d;

    function automatic logic legal_f3(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !we;
            3'b011:                 ok = (XLEN == 64);
            3'b110:                 ok = (XLEN == 64) && !we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_cross(input logic [OW-1:0] off, input logic [1:0] sz);
        logic [4:0] bytes;
        logic [4:0] sum;
        bytes = 5'd1 << sz;
        sum   = 5'(off) + bytes;
        return sum > 5'(NB);
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << sz));
        end
        return m;
    endfunction

    // Shift the beat pair down to the access offset, then fill above the
    // access width with the sign bit (signed codes) or zero (unsigned codes).
    function automatic logic [XLEN-1:0] ext_load(input logic [2*XLEN-1:0] pair,
                                                 input logic [OW-1:0]     off,
                                                 input logic [2:0]        f3);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   raw;
        logic [XLEN-1:0]   res;
        logic              sb;
        int                nbits;
        sh    = pair >> {off, 3'b000};
        raw   = sh[XLEN-1:0];
        nbits = 8 << f3[1:0];
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        case (f3[1:0])
            2'b00:   sb = raw[7];
            2'b01:   sb = raw[15];
            2'b10:   sb = raw[31];
            default: sb = raw[XLEN-1];
        endcase
        if (f3[2]) begin
            sb = 1'b0;
        end
        res = raw;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= nbits) begin
                res[i] = sb;
            end
        end
        return res;
    endfunction

    logic [OW-1:0]     off_q;
    logic [OW-1:0]     in_off;
    logic              in_cross;
    logic              in_legal;
    logic [2*NB-1:0]   full_sel;
    logic [2*XLEN-1:0] full_wd;
    logic [XLEN-1:0]   base_addr;
    logic [XLEN-1:0]   next_addr;

    always_comb begin
        off_q     = addr_q[OW-1:0];
        in_off    = i_dmem_intf_addr[OW-1:0];
        in_cross  = is_cross(in_off, i_dmem_intf_func3[1:0]);
        in_legal  = legal_f3(i_dmem_intf_func3, i_dmem_intf_we);
        full_sel  = {{NB{1'b0}}, size_mask(f3_q[1:0])} << off_q;
        full_wd   = {{XLEN{1'b0}}, wd_q} << {off_q, 3'b000};
        base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
        // Natural XLEN-bit addition gives the modulo-2^XLEN wrap for beat 1.
        next_addr = base_addr + XLEN'(NB);
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wd_d              = wd_q;
        lo_d              = lo_q;
        rd_d              = rd_q;
        we_d              = we_q;
        cross_d           = cross_q;
        f3_d              = f3_q;
        o_dmem_intf_ready = 1'b0;
        o_dmem_intf_done  = 1'b0;
        o_dmem_intf_err   = 1'b0;
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_addr        = '0;
        o_mem_wr_data     = '0;
        o_mem_byte_sel    = '0;

        case (state_q)
            S_IDLE: begin
                o_dmem_intf_ready = 1'b1;
                if (i_dmem_intf_req) begin
                    addr_d  = i_dmem_intf_addr;
                    wd_d    = i_dmem_intf_wr_data;
                    we_d    = i_dmem_intf_we;
                    f3_d    = i_dmem_intf_func3;
                    cross_d = in_cross;
                    lo_d    = '0;
                    if (!in_legal || (in_cross && !MISALIGN_EN)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                o_mem_req      = 1'b1;
                o_mem_we       = we_q;
                o_mem_addr     = base_addr;
                o_mem_wr_data  = full_wd[XLEN-1:0];
                o_mem_byte_sel = full_sel[NB-1:0];
                if (i_mem_gnt) begin
                    if (!we_q) begin
                        state_d = S_WAIT0;
                    end else if (cross_q) begin
                        state_d = S_REQ1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT0: begin
                if (i_mem_rd_valid) begin
                    lo_d = i_mem_rd_data;
                    if (cross_q) begin
                        state_d = S_REQ1;
                    end else begin
                        rd_d    = ext_load({{XLEN{1'b0}}, i_mem_rd_data}, off_q, f3_q);
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ1: begin
                o_mem_req      = 1'b1;
                o_mem_we       = we_q;
                o_mem_addr     = next_addr;
                o_mem_wr_data  = full_wd[2*XLEN-1:XLEN];
                o_mem_byte_sel = full_sel[2*NB-1:NB];
                if (i_mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (i_mem_rd_valid) begin
                    rd_d    = ext_load({i_mem_rd_data, lo_q}, off_q, f3_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_dmem_intf_done = 1'b1;
                state_d          = S_IDLE;
            end
            S_ERR: begin
                o_dmem_intf_err = 1'b1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            lo_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            cross_q <= 1'b0;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            cross_q <= cross_d;
            f3_q    <= f3_d;
        end
    end

    assign o_dmem_intf_rd_data = rd_q;

endmodule

// File: doc/riscv_dmem_interface_split.md
Name: riscv_dmem_interface_split

Overview:
Parametrised data-memory interface between the RV32I/RV64I LSU and a handshaked data-memory port. It aligns store data and byte selects, and extracts and sign/zero-extends load data for XLEN 32 or 64. Unlike the combinational predecessor, it is a sequential FSM. It splits accesses that cross a word boundary into two memory transactions and merges the returned halves. It also tolerates memory grant and read-latency stalls.

Parameters:
XLEN, 32, data/address width; 32 or 64 only.
MISALIGN_EN, 1, 1: split word-crossing accesses; 0: flag them as an error with no memory access.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_dmem_intf_req  input  1  CPU access request; sampled only when o_dmem_intf_ready=1
i_dmem_intf_we  input  1  1=store, 0=load
i_dmem_intf_addr  input  XLEN  byte address
i_dmem_intf_wr_data  input  XLEN  store data, LSB-aligned
i_dmem_intf_func3  input  3  RISC-V funct3 size/sign code
o_dmem_intf_ready  output  1  FSM idle; can accept a request
o_dmem_intf_done  output  1  1-cycle pulse on completion of a load or store
o_dmem_intf_rd_data  output  XLEN  extended load data; valid while done=1 and the access was a load
o_dmem_intf_err  output  1  1-cycle pulse: illegal func3, or crossing access with MISALIGN_EN=0
o_mem_req  output  1  memory request; held until i_mem_gnt
o_mem_we  output  1  memory write enable
o_mem_addr  output  XLEN  word-aligned memory address
o_mem_wr_data  output  XLEN  lane-aligned write data
o_mem_byte_sel  output  XLEN/8  byte-lane enables
i_mem_gnt  input  1  memory accepts the current request this cycle
i_mem_rd_valid  input  1  read data valid; at least 1 cycle after gnt
i_mem_rd_data  input  XLEN  memory read word

Behaviour:
- Definitions:
  - NB = XLEN/8.
  - off = addr[log2(NB)-1:0].
  - size from func3[1:0]: 00→1, 01→2, 10→4, 11→8 bytes.
  - Legal func3 values: 000, 001, 010, 100, 101. XLEN=64 additionally allows 011 (LD/SD) and 110 (LWU). 111 is always illegal.
  - Stores use func3[1:0] only; a store with func3[2]=1 is illegal.
  - cross = (off + size > NB).
- State on accept: latched addr, we, wr_data, func3, off, cross. Inputs are ignored after acceptance.
- Lane alignment:
  - full_sel = (size-bit mask) << off, 2*NB bits wide.
  - full_wd = wr_data << 8*off, 2*XLEN bits wide.
  - Beat 0 uses the low halves of full_sel and full_wd; beat 1 uses the high halves.
  - Beat 0 address = addr with low log2(NB) bits cleared; beat 1 address = beat 0 address + NB.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR.
  - IDLE: ready=1. On req:
    - illegal func3, or (cross and MISALIGN_EN=0) → ERR;
    - otherwise → REQ0.
  - REQ0: o_mem_req=1 with beat-0 fields. Outputs stay stable until gnt. On gnt:
    - store, not cross → DONE;
    - store, cross → REQ1;
    - load → WAIT0.
  - WAIT0: on i_mem_rd_valid, capture lo=i_mem_rd_data; then → REQ1 if cross, else → DONE.
  - REQ1: beat-1 fields; held until gnt. On gnt: store → DONE; load → WAIT1.
  - WAIT1: on rd_valid, capture hi → DONE.
  - DONE: done=1 for 1 cycle. For loads, o_dmem_intf_rd_data is registered and set. Next state IDLE.
  - ERR: err=1 for 1 cycle, no o_mem_req, done stays 0. Next state IDLE.
- Load data path:
  - ext = ({hi,lo} >> 8*off)[XLEN-1:0], with hi=0 when not cross.
  - Extend per func3: sign-extend for 000/001/010; zero-extend for 100/101/110.
  - 011 passes all 64 bits through.
- Latency with zero-wait memory (gnt in REQ, rd_valid the next cycle):
  - aligned load: done 3 cycles after acceptance;
  - aligned store: done 2 cycles after acceptance;
  - crossing load: 5 cycles; crossing store: 3 cycles.
- Boundaries:
  - i_mem_rd_valid outside WAIT0/WAIT1 is ignored.
  - req while ready=0 is ignored; the CPU must hold it.
  - gnt outside REQ0/REQ1 is ignored.
  - Address wrap at 2^XLEN in beat 1 wraps modulo 2^XLEN.
- Reset (asynchronous):
  - State goes to IDLE; any in-flight transaction is abandoned.
  - Outputs: ready=1; done, err, o_mem_req, o_mem_we = 0; o_mem_addr, o_mem_wr_data, o_mem_byte_sel, o_dmem_intf_rd_data = 0.
  - The memory side tolerates abandoned requests.
- When not requesting, o_mem_* data outputs are 0.

Test Plan:
1. XLEN=32; memory word 0x100 holds 0x8899AABB.
   - LB @0x101 → o_mem_addr=0x100, byte_sel=4'b0010, rd_data=0xFFFFFFAA.
   - LBU @0x101 → rd_data=0x000000AA.
   - Both complete with done 3 cycles after acceptance.
2. MISALIGN_EN=1; memory 0x100=0x8899AABB, 0x104=0x11223344.
   - LW @0x103 → two requests: 0x100/sel 4'b1000, then 0x104/sel 4'b0111.
   - rd_data=0x22334488; done 5 cycles after acceptance.
3. SH 0x0000BEEF @0x103 →
   - REQ0: addr 0x100, sel 4'b1000, wr_data[31:24]=0xEF;
   - REQ1: addr 0x104, sel 4'b0001, wr_data[7:0]=0xBE;
   - done pulse follows.
4. MISALIGN_EN=0, LH @0x103 → err=1 for exactly 1 cycle, o_mem_req never asserted, done=0, ready returns to 1. Same response for func3=111 in either mode.
5. i_mem_gnt held low 3 cycles during REQ0 of SW 0xDEADBEEF @0x200 → o_mem_req, addr, sel=4'b1111 and data stable all 4 cycles; ready=0; done 1 cycle after gnt.
6. Assert i_rst while in WAIT0, then pulse i_mem_rd_valid after release → all outputs at reset values, no done pulse, next request processed normally. XLEN=64 check: LD @0x1004 crosses → two beats at 0x1000 and 0x1008, with 64-bit merged data.
